// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with byte-enable writes, optional bypass and zero-register,
// and a sequential clear engine that zeroes one register per cycle.
module regfile_param #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    readReg1,
    input  logic [ADDR_W-1:0]    readReg2,
    input  logic [ADDR_W-1:0]    writeReg,
    input  logic [WIDTH-1:0]     writeData,
    input  logic                 regWrite,
    input  logic [WIDTH/8-1:0]   byteEn,
    input  logic                 clearReq,
    output logic [WIDTH-1:0]     readData1,
    output logic [WIDTH-1:0]     readData2,
    output logic                 busy,
    output logic                 writeDrop
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB = WIDTH / 8;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                write_drop_q, write_drop_d;
    logic [WIDTH-1:0]    regs_q [DEPTH];
    logic [WIDTH-1:0]    regs_d [DEPTH];
    logic [WIDTH-1:0]    merged;
    logic                write_ok;

    assign busy      = state_q == CLEAR;
    assign writeDrop = write_drop_q;
    assign write_ok  = regWrite && !busy;

    // Stored word with the enabled bytes replaced; shared by the write path and the bypass.
    always_comb begin
        merged = regs_q[writeReg];
        for (int b = 0; b < NB; b++)
            if (byteEn[b]) merged[8*b +: 8] = writeData[8*b +: 8];
    end

    always_comb begin
        regs_d = regs_q;
        if (write_ok && !(ZERO_R0 != 0 && writeReg == '0)) regs_d[writeReg] = merged;
        if (busy) regs_d[ptr_q] = '0;
        state_d      = busy ? ((ptr_q == LAST) ? IDLE : CLEAR) : (clearReq ? CLEAR : IDLE);
        ptr_d        = busy ? ptr_q + 1'b1 : '0;
        write_drop_d = regWrite && busy;
    end

    assign readData1 = (ZERO_R0 != 0 && readReg1 == '0) ? '0 :
                       (BYPASS != 0 && write_ok && writeReg == readReg1) ? merged : regs_q[readReg1];
    assign readData2 = (ZERO_R0 != 0 && readReg2 == '0) ? '0 :
                       (BYPASS != 0 && write_ok && writeReg == readReg2) ? merged : regs_q[readReg2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            write_drop_q <= 1'b0;
            regs_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            write_drop_q <= write_drop_d;
            regs_q       <= regs_d;
        end
    end
endmodule
